// File: rtl/controller_v2.sv
// Instruction-sequencing controller: fetch/decode/execute FSM with a bounded
// fetch wait and a sticky fault state. Outputs decode the state register and op.
module controller_v2 #(
  parameter int OPW     = 4,
  parameter int ALUW    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            CLB,
  input  logic            z,
  input  logic            c,
  input  logic [OPW-1:0]  op,
  input  logic            mem_ack,
  input  logic            resume,
  output logic            mem_req,
  output logic            LoadIR,
  output logic            IncPC,
  output logic            SelPC,
  output logic            LoadPC,
  output logic            LoadReg,
  output logic            LoadAcc,
  output logic [1:0]      SelACC,
  output logic [ALUW-1:0] SelALU,
  output logic            halted,
  output logic            fault,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_JUMP   = 3'b010,
    S_EXEC   = 3'b011,
    S_STORE  = 3'b100,
    S_HALT   = 3'b101,
    S_FAULT  = 3'b110,
    S_INIT   = 3'b111
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZRS = 4'b0110;
  localparam logic [3:0] OP_JZIM = 4'b0111;
  localparam logic [3:0] OP_JCRS = 4'b1000;
  localparam logic [3:0] OP_JCIM = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_LDIM = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] opc_s;
  logic       legal_s;

  // Upper opcode bits must be clear; 1001 and 1110 are unassigned.
  function automatic logic op_legal(input logic [OPW-1:0] o);
    logic [OPW-1:0] hi;
    hi = o >> 3'd4;
    return (hi == {OPW{1'b0}}) && (o[3:0] != 4'b1001) && (o[3:0] != 4'b1110);
  endfunction

  assign opc_s   = op[3:0];
  assign legal_s = op_legal(op);

  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q <= S_INIT;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The wait counter only survives consecutive unacknowledged FETCH cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = 8'd0;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_FETCH;
          wait_d  = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (!legal_s) begin
          state_d = S_FAULT;
        end else begin
          case (opc_s)
            OP_NOP:                            state_d = S_FETCH;
            OP_ADD, OP_SUB, OP_NOR, OP_MOVR,
            OP_SHL, OP_SHR, OP_LDIM:           state_d = S_EXEC;
            OP_MOVA:                           state_d = S_STORE;
            OP_JZRS, OP_JZIM:                  state_d = z ? S_JUMP : S_FETCH;
            OP_JCRS, OP_JCIM:                  state_d = c ? S_JUMP : S_FETCH;
            OP_HALT:                           state_d = S_HALT;
            default:                           state_d = S_FAULT;
          endcase
        end
      end
      S_JUMP:  state_d = S_FETCH;
      S_EXEC:  state_d = S_FETCH;
      S_STORE: state_d = S_FETCH;
      S_HALT:  state_d = resume ? S_FETCH : S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Reset forces the INIT output pattern even before the state register updates.
  always_comb begin
    mem_req = 1'b0;
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = 1'b0;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelACC  = 2'b00;
    SelALU  = {ALUW{1'b0}};
    halted  = 1'b0;
    fault   = 1'b0;
    state_o = state_q;
    if (CLB) begin
      state_o = S_INIT;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          LoadIR  = mem_ack;
        end
        S_DECODE: IncPC = 1'b1;
        S_JUMP: begin
          LoadPC = 1'b1;
          SelPC  = (opc_s == OP_JZRS) || (opc_s == OP_JCRS);
        end
        S_EXEC: begin
          LoadAcc = 1'b1;
          SelACC  = (opc_s == OP_MOVR) ? 2'b10 : ((opc_s == OP_LDIM) ? 2'b11 : 2'b00);
          SelALU  = ALUW'(opc_s);
        end
        S_STORE: LoadReg = 1'b1;
        S_HALT:  halted  = 1'b1;
        S_FAULT: fault   = 1'b1;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller_v2.sv
// Randomized bench for controller_v2: each instruction is expanded into the
// per-cycle state/output trace its semantics imply, then compared cycle by cycle.
module tb_controller_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       CLB = 1'b1;
  logic       z = 1'b0, c = 1'b0, mem_ack = 1'b0, resume = 1'b0;
  logic [3:0] op = 4'd0;
  logic [5:0] op_b = 6'd0;

  logic       mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, halted, fault;
  logic [1:0] SelACC;
  logic [3:0] SelALU;
  logic [2:0] state_o;

  logic       mem_req_b, LoadIR_b, IncPC_b, SelPC_b, LoadPC_b, LoadReg_b, LoadAcc_b, halted_b, fault_b;
  logic [1:0] SelACC_b;
  logic [5:0] SelALU_b;
  logic [2:0] state_o_b;

  controller_v2 dut (
    .clk(clk), .CLB(CLB), .z(z), .c(c), .op(op), .mem_ack(mem_ack), .resume(resume),
    .mem_req(mem_req), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelACC(SelACC), .SelALU(SelALU),
    .halted(halted), .fault(fault), .state_o(state_o)
  );

  controller_v2 #(.OPW(6), .ALUW(6), .TIMEOUT(3)) dut_b (
    .clk(clk), .CLB(CLB), .z(z), .c(c), .op(op_b), .mem_ack(mem_ack), .resume(resume),
    .mem_req(mem_req_b), .LoadIR(LoadIR_b), .IncPC(IncPC_b), .SelPC(SelPC_b), .LoadPC(LoadPC_b),
    .LoadReg(LoadReg_b), .LoadAcc(LoadAcc_b), .SelACC(SelACC_b), .SelALU(SelALU_b),
    .halted(halted_b), .fault(fault_b), .state_o(state_o_b)
  );

  localparam logic [2:0] ST_INIT = 3'b111, ST_FETCH = 3'b000, ST_DECODE = 3'b001, ST_JUMP = 3'b010;
  localparam logic [2:0] ST_EXEC = 3'b011, ST_STORE = 3'b100, ST_HALT = 3'b101, ST_FAULT = 3'b110;
  // control bit order: {mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc}
  localparam logic [6:0] C_NONE = 7'b0000000, C_REQ = 7'b1000000, C_REQIR = 7'b1100000;
  localparam logic [6:0] C_INC = 7'b0010000, C_REG = 7'b0000010, C_ACC = 7'b0000001;

  logic [17:0] obs;
  assign obs = {state_o, mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
                SelACC, SelALU, halted, fault};

  typedef struct packed {
    logic        ack;
    logic        res;
    logic [17:0] want;
  } step_t;

  step_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [17:0] ev(input logic [2:0] st, input logic [6:0] ctl,
                                     input logic [1:0] sacc, input logic [3:0] salu,
                                     input logic h, input logic f);
    return {st, ctl, sacc, salu, h, f};
  endfunction

  function automatic void push(input logic ack, input logic res, input logic [17:0] w);
    step_t s;
    s.ack = ack;
    s.res = res;
    s.want = w;
    q.push_back(s);
  endfunction

  // Expected trace of one instruction starting on the first FETCH cycle.
  function automatic void plan_instr(input logic [3:0] o, input logic zz, input logic cc,
                                     input int dly, input int hold);
    logic taken;
    for (int i = 0; i < dly; i++) push(1'b0, 1'($urandom), ev(ST_FETCH, C_REQ, 2'b00, 4'd0, 1'b0, 1'b0));
    push(1'b1, 1'($urandom), ev(ST_FETCH, C_REQIR, 2'b00, 4'd0, 1'b0, 1'b0));
    push(1'($urandom), 1'($urandom), ev(ST_DECODE, C_INC, 2'b00, 4'd0, 1'b0, 1'b0));
    case (o)
      4'd0: begin end
      4'd1, 4'd2, 4'd3, 4'd11, 4'd12:
        push(1'($urandom), 1'($urandom), ev(ST_EXEC, C_ACC, 2'b00, o, 1'b0, 1'b0));
      4'd4: push(1'($urandom), 1'($urandom), ev(ST_EXEC, C_ACC, 2'b10, o, 1'b0, 1'b0));
      4'd13: push(1'($urandom), 1'($urandom), ev(ST_EXEC, C_ACC, 2'b11, o, 1'b0, 1'b0));
      4'd5: push(1'($urandom), 1'($urandom), ev(ST_STORE, C_REG, 2'b00, 4'd0, 1'b0, 1'b0));
      4'd6, 4'd7, 4'd8, 4'd10: begin
        taken = (o == 4'd6 || o == 4'd7) ? zz : cc;
        if (taken)
          push(1'($urandom), 1'($urandom),
               ev(ST_JUMP, {3'b000, (o == 4'd6 || o == 4'd8), 1'b1, 2'b00}, 2'b00, 4'd0, 1'b0, 1'b0));
      end
      4'd15: begin
        for (int i = 0; i < hold; i++) push(1'($urandom), 1'b0, ev(ST_HALT, C_NONE, 2'b00, 4'd0, 1'b1, 1'b0));
        push(1'($urandom), 1'b1, ev(ST_HALT, C_NONE, 2'b00, 4'd0, 1'b1, 1'b0));
      end
      default:
        for (int i = 0; i < 4; i++) push(1'($urandom), 1'(i % 2), ev(ST_FAULT, C_NONE, 2'b00, 4'd0, 1'b0, 1'b1));
    endcase
  endfunction

  task automatic run_queue(input string name);
    step_t s;
    int n;
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ack = s.ack;
      resume = s.res;
      #1;
      checks++;
      if (obs !== s.want) begin
        failures++;
        $display("FAIL %s cycle %0d: state+outputs got %h, expected %h", name, n, obs, s.want);
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic expect_fetch(input string name);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (state_o !== ST_FETCH) begin
      failures++;
      $display("FAIL %s: state_o got %b, expected %b", name, state_o, ST_FETCH);
    end
  endtask

  task automatic test_reset();
    logic [17:0] init_w;
    init_w = ev(ST_INIT, C_NONE, 2'b00, 4'd0, 1'b0, 1'b0);
    CLB = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_ack = 1'($urandom);
      resume = 1'($urandom);
      #1;
      checks++;
      if (obs !== init_w) begin
        failures++;
        $display("FAIL reset_hold: got %h, expected %h", obs, init_w);
      end
      @(posedge clk);
      #1;
    end
    CLB = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (obs !== init_w) begin
      failures++;
      $display("FAIL reset_release_init: got %h, expected %h", obs, init_w);
    end
    @(posedge clk);
    #1;
    expect_fetch("reset_first_fetch");
  endtask

  task automatic test_add();
    op = 4'b0001;
    z = 1'($urandom);
    c = 1'($urandom);
    plan_instr(op, z, c, 0, 0);
    run_queue("add_first_fetch");
    expect_fetch("add_back_to_fetch");
  endtask

  task automatic test_jumps();
    logic [3:0] ops [4];
    ops[0] = 4'b0110; ops[1] = 4'b0111; ops[2] = 4'b1000; ops[3] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      for (int t = 0; t < 2; t++) begin
        op = ops[i];
        z = 1'(t);
        c = 1'(t);
        plan_instr(op, z, c, $urandom_range(0, 2), 0);
        run_queue("jump");
        expect_fetch("jump_return");
      end
    end
  endtask

  task automatic test_timeout();
    op = 4'b0001;
    for (int i = 0; i < 16; i++) push(1'b0, 1'b0, ev(ST_FETCH, C_REQ, 2'b00, 4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) push(1'($urandom), 1'(i % 2), ev(ST_FAULT, C_NONE, 2'b00, 4'd0, 1'b0, 1'b1));
    run_queue("timeout_fault");
    test_reset();
    plan_instr(op, 1'b0, 1'b0, 15, 0);
    run_queue("timeout_ack_wins");
    expect_fetch("timeout_ack_wins_return");
  endtask

  task automatic test_halt();
    op = 4'b1111;
    plan_instr(op, 1'b0, 1'b0, 1, 10);
    run_queue("halt_resume");
    expect_fetch("halt_to_fetch");
  endtask

  task automatic test_illegal();
    op = 4'b1001;
    plan_instr(op, 1'b0, 1'b0, 0, 0);
    run_queue("illegal_1001");
    test_reset();
    op = 4'b1110;
    plan_instr(op, 1'b0, 1'b0, 2, 0);
    run_queue("illegal_1110");
    test_reset();
  endtask

  task automatic test_opw6();
    op = 4'b0000;
    op_b = 6'b010001;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++;
    if (state_o_b !== ST_DECODE || IncPC_b !== 1'b1) begin
      failures++;
      $display("FAIL opw6_decode: state %b inc %b, expected %b 1", state_o_b, IncPC_b, ST_DECODE);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state_o_b !== ST_FAULT || fault_b !== 1'b1) begin
      failures++;
      $display("FAIL opw6_upper_bits_fault: state %b fault %b, expected %b 1", state_o_b, fault_b, ST_FAULT);
    end
    test_reset();
    op_b = 6'b000001;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (state_o_b !== ST_EXEC || SelALU_b !== 6'b000001 || LoadAcc_b !== 1'b1) begin
      failures++;
      $display("FAIL opw6_add_exec: state %b selalu %b ldacc %b, expected %b 000001 1",
               state_o_b, SelALU_b, LoadAcc_b, ST_EXEC);
    end
    test_reset();
    // second instance has TIMEOUT=3: four unacknowledged FETCH cycles, then FAULT
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state_o_b !== ST_FETCH) begin
        failures++;
        $display("FAIL opw6_timeout_wait %0d: state %b, expected %b", i, state_o_b, ST_FETCH);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (state_o_b !== ST_FAULT || state_o !== ST_FETCH) begin
      failures++;
      $display("FAIL opw6_timeout3: b state %b a state %b, expected %b %b", state_o_b, state_o, ST_FAULT, ST_FETCH);
    end
    test_reset();
    op_b = 6'd0;
  endtask

  task automatic test_reset_mid_exec();
    op = 4'b0001;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (state_o !== ST_EXEC || LoadAcc !== 1'b1) begin
      failures++;
      $display("FAIL mid_exec_pre: state %b ldacc %b, expected %b 1", state_o, LoadAcc, ST_EXEC);
    end
    CLB = 1'b1;
    #1;
    checks++;
    if (state_o !== ST_INIT || LoadAcc !== 1'b0) begin
      failures++;
      $display("FAIL mid_exec_reset_cycle: state %b ldacc %b, expected %b 0", state_o, LoadAcc, ST_INIT);
    end
    @(posedge clk);
    #1;
    CLB = 1'b0;
    #1;
    checks++;
    if (obs !== ev(ST_INIT, C_NONE, 2'b00, 4'd0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL mid_exec_init: got %h, expected INIT pattern", obs);
    end
    @(posedge clk);
    #1;
    expect_fetch("mid_exec_refetch");
  endtask

  task automatic test_random();
    logic [3:0] o;
    for (int n = 0; n < 40; n++) begin
      do o = 4'($urandom_range(0, 15)); while (o == 4'd9 || o == 4'd14);
      op = o;
      z = 1'($urandom);
      c = 1'($urandom);
      plan_instr(o, z, c, (n % 10 == 9) ? 15 : $urandom_range(0, 6), $urandom_range(0, 4));
      run_queue("random");
    end
    expect_fetch("random_end");
  endtask

  initial begin
    test_reset();
    test_add();
    test_jumps();
    test_timeout();
    test_halt();
    test_illegal();
    test_opw6();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
